square_seq: RTL and testbench

Sequential 32-bit integer squarer, the inverse of the ISR block: takes a 32-bit root and produces its exact 64-bit square using an iterative shift-add multiplier. It generates ISR stimulus with known answers and closes the round trip `ISR(square_seq(x)) == x` for self-checking tests. It uses the same done-based handshake as ISR and accepts one operation at a time.

---
 rtl/isr_pkg.sv | 19 +
 rtl/square_seq_step.sv | 27 ++
 rtl/square_seq.sv | 113 +++++++++++
 tb/tb_square_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/isr_pkg.sv
// Widths and state encoding shared by the integer square-root block and its
// companion squarer, so both sides of the round trip agree on operand sizes.
package isr_pkg;

    localparam int ISR_VALUE_W = 64;
    localparam int ISR_ROOT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sq_state_t;

    // Number of shift-add iterations needed to consume the whole root.
    function automatic int sq_iter(input int bits_per_cycle);
        return ISR_ROOT_W / bits_per_cycle;
    endfunction

endpackage

// File: rtl/square_seq_step.sv
// One shift-add iteration of the squarer: adds mcand times the low multiplier
// field into acc, then advances both operands by BITS_PER_CYCLE bits.
module sq_step
    import isr_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic [ISR_VALUE_W-1:0] acc,
    input  logic [ISR_VALUE_W-1:0] mcand,
    input  logic [ISR_ROOT_W-1:0]  mplier,
    output logic [ISR_VALUE_W-1:0] acc_next,
    output logic [ISR_VALUE_W-1:0] mcand_next,
    output logic [ISR_ROOT_W-1:0]  mplier_next
);

    logic [BITS_PER_CYCLE-1:0] field;
    logic [ISR_VALUE_W-1:0]    partial;

    assign field = mplier[BITS_PER_CYCLE-1:0];

    // Product is truncated to 64 bits; acc itself can never exceed (2^32-1)^2.
    assign partial     = mcand * ISR_VALUE_W'(field);
    assign acc_next    = acc + partial;
    assign mcand_next  = mcand << BITS_PER_CYCLE;
    assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/square_seq.sv
// Sequential 32-bit squarer: iterative shift-add multiply of value by itself,
// producing the exact 64-bit square after a data-independent ITER cycles.
module square_seq
    import isr_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ISR_ROOT_W-1:0]  value,
    output logic [ISR_VALUE_W-1:0] result,
    output logic                   done,
    output sq_state_t              state
);

    localparam int         ITER = sq_iter(BITS_PER_CYCLE);
    localparam logic [5:0] LAST = 6'(ITER - 1);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bits_per_cycle
        $error("square_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    sq_state_t              state_q, state_d;
    logic [ISR_VALUE_W-1:0] acc_q, acc_d;
    logic [ISR_VALUE_W-1:0] mcand_q, mcand_d;
    logic [ISR_ROOT_W-1:0]  mplier_q, mplier_d;
    logic [5:0]             count_q, count_d;
    logic [ISR_VALUE_W-1:0] result_q, result_d;
    logic                   done_q, done_d;

    logic [ISR_VALUE_W-1:0] step_acc;
    logic [ISR_VALUE_W-1:0] step_mcand;
    logic [ISR_ROOT_W-1:0]  step_mplier;

    sq_step #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .acc_next    (step_acc),
        .mcand_next  (step_mcand),
        .mplier_next (step_mplier)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Handshake: a start seen at a rising edge in IDLE or DONE is accepted and
    // drops done; start in BUSY is ignored. done rises with result on the
    // ITER-th edge after acceptance and holds, with result, until the next
    // accepted start or reset. result only changes on that completing edge.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = {{(ISR_VALUE_W-ISR_ROOT_W){1'b0}}, value};
                    mplier_d = value;
                    acc_d    = '0;
                    count_d  = '0;
                    done_d   = 1'b0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = step_mcand;
                mplier_d = step_mplier;
                count_d  = count_q + 6'd1;
                if (count_q == LAST) begin
                    result_d = step_acc;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign done   = done_q;
    assign state  = state_q;

endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq: four instances (1/2/4/8 bits per cycle) share
// start/value so every vector also checks latency across the parameter sweep.
module tb_square_seq;
    import isr_pkg::*;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] value;

    logic [63:0] res [4];
    logic        dn  [4];
    sq_state_t   st  [4];

    int tests;
    int fails;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        square_seq #(
            .BITS_PER_CYCLE(1 << g)
        ) dut (
            .clock  (clock),
            .reset  (reset),
            .start  (start),
            .value  (value),
            .result (res[g]),
            .done   (dn[g]),
            .state  (st[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Start one operation on all instances and check latency and square on each.
    task automatic run_op(input logic [31:0] v, input logic [63:0] exp, input string tag);
        int  lat  [4];
        bit  seen [4];
        int  c;
        start = 1'b1;
        value = v;
        next_cycle();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s done_fall[%0d]", tag, k), 64'(dn[k]), 64'd0);
            lat[k]  = 0;
            seen[k] = 1'b0;
        end
        c = 0;
        while (!(seen[0] && seen[1] && seen[2] && seen[3]) && c < 40) begin
            next_cycle();
            c++;
            for (int k = 0; k < 4; k++) begin
                if (!seen[k] && dn[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = c;
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s latency[%0d]", tag, k), 64'(lat[k]), 64'(32 >> k));
            check($sformatf("%s result[%0d]", tag, k), res[k], exp);
        end
    endtask

    // Wait for the default instance to finish; returns edges counted.
    task automatic wait_done1(output int c);
        c = 0;
        while (!dn[1] && c < 40) begin
            next_cycle();
            c++;
        end
    endtask

    initial begin
        int          c;
        logic [31:0] r;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        value = '0;

        #12;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset done[%0d]", k), 64'(dn[k]), 64'd0);
            check($sformatf("reset result[%0d]", k), res[k], 64'd0);
            check($sformatf("reset state[%0d]", k), 64'(st[k]), 64'(IDLE));
        end
        @(negedge clock);
        reset = 1'b0;
        next_cycle();

        run_op(32'd10, 64'd100, "v10");
        run_op(32'd15, 64'd225, "v15");
        run_op(32'd0, 64'd0, "v0");
        run_op(32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "vmax");
        run_op(32'h0001_0000, 64'h0000_0001_0000_0000, "v2p16");
        run_op(32'h8000_0000, 64'h4000_0000_0000_0000, "v2p31");
        run_op(32'd65535, 64'd4294836225, "v65535");
        run_op(32'd46341, 64'd2147488281, "v46341");

        // Start 7, then a second start carrying 9 on the fifth BUSY edge.
        start = 1'b1;
        value = 32'd7;
        next_cycle();
        start = 1'b0;
        value = 32'd0;
        repeat (4) next_cycle();
        start = 1'b1;
        value = 32'd9;
        next_cycle();
        start = 1'b0;
        value = 32'd0;
        check("ign state[1]", 64'(st[1]), 64'(BUSY));
        c = 5;
        while (!dn[1] && c < 40) begin
            next_cycle();
            c++;
        end
        check("ign latency[1]", 64'(c), 64'd16);
        check("ign result[1]", res[1], 64'd49);
        repeat (20) next_cycle();
        check("ign hold state[1]", 64'(st[1]), 64'(DONE));
        check("ign hold result[0]", res[0], 64'd49);
        check("ign hold result[1]", res[1], 64'd49);
        check("ign hold result[2]", res[2], 64'd49);
        check("ign hold result[3]", res[3], 64'd81);

        // Asynchronous reset on the eighth BUSY cycle.
        start = 1'b1;
        value = 32'd300;
        next_cycle();
        start = 1'b0;
        repeat (8) next_cycle();
        check("pre-reset state[1]", 64'(st[1]), 64'(BUSY));
        reset = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid reset done[%0d]", k), 64'(dn[k]), 64'd0);
            check($sformatf("mid reset result[%0d]", k), res[k], 64'd0);
            check($sformatf("mid reset state[%0d]", k), 64'(st[k]), 64'(IDLE));
        end
        @(negedge clock);
        reset = 1'b0;
        next_cycle();
        check("post reset state[1]", 64'(st[1]), 64'(IDLE));
        check("post reset result[1]", res[1], 64'd0);
        run_op(32'd300, 64'd90000, "v300");

        // Back-to-back on the default instance with start held high.
        start = 1'b1;
        value = 32'd3;
        next_cycle();
        value = 32'd4;
        wait_done1(c);
        check("b2b latency 3", 64'(c), 64'd16);
        check("b2b result 3", res[1], 64'd9);
        next_cycle();
        check("b2b done fall 4", 64'(dn[1]), 64'd0);
        check("b2b hold old 9", res[1], 64'd9);
        value = 32'd5;
        wait_done1(c);
        check("b2b low cycles 4", 64'(c), 64'd16);
        check("b2b result 4", res[1], 64'd16);
        next_cycle();
        check("b2b done fall 5", 64'(dn[1]), 64'd0);
        start = 1'b0;
        wait_done1(c);
        check("b2b low cycles 5", 64'(c), 64'd16);
        check("b2b result 5", res[1], 64'd25);
        repeat (40) next_cycle();

        // Random roots against a software square.
        for (int i = 0; i < 100; i++) begin
            r = $urandom_range(32'hFFFF_FFFF, 0);
            run_op(r, 64'(r) * 64'(r), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
